// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with buffered
// long-latency results, squashing stale queued writes on a same-register ALU write.
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_we,
    input  logic [AW-1:0]              alu_wa,
    input  logic [DW-1:0]              alu_wd,
    input  logic                       lng_valid,
    output logic                       lng_ready,
    input  logic [AW-1:0]              lng_wa,
    input  logic [DW-1:0]              lng_wd,
    output logic                       we3,
    output logic [AW-1:0]              wa3,
    output logic [DW-1:0]              wd3,
    output logic [31:0]                busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW-1:0] XZR = AW'(31);

    logic [DEPTH-1:0] live;
    logic [AW-1:0]    wa_mem [DEPTH];
    logic [DW-1:0]    wd_mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;

    logic alu_take, push, pop;

    assign lng_ready  = !reset && (count != CW'(DEPTH));
    assign alu_take   = alu_we && (alu_wa != XZR);
    assign push       = lng_valid && lng_ready && (lng_wa != XZR);
    assign pop        = !alu_take && (count != '0);
    assign fifo_count = count;

    // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) busy[wa_mem[i]] = 1'b1;
        end
        busy[31] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            we3    <= 1'b0;
            wa3    <= '0;
            wd3    <= '0;
        end else begin
            // Kill older queued writes to the register the ALU overwrites now;
            // a same-edge push is younger, so its set below takes precedence.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_take && (wa_mem[i] == alu_wa)) live[i] <= 1'b0;
            end

            if (alu_take) begin
                we3 <= 1'b1;
                wa3 <= alu_wa;
                wd3 <= alu_wd;
            end else if (pop) begin
                we3          <= live[rd_ptr];
                wa3          <= wa_mem[rd_ptr];
                wd3          <= wd_mem[rd_ptr];
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + 1'b1;
            end else begin
                we3 <= 1'b0;
            end

            if (push) begin
                live[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage has no reset; the live bits alone decide whether a slot means anything.
    always_ff @(posedge clk) begin
        if (push) begin
            wa_mem[wr_ptr] <= lng_wa;
            wd_mem[wr_ptr] <= lng_wd;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_wb_write_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_we;
    logic [AW-1:0] alu_wa;
    logic [DW-1:0] alu_wd;
    logic          lng_valid;
    logic          lng_ready;
    logic [AW-1:0] lng_wa;
    logic [DW-1:0] lng_wd;
    logic          we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic [31:0]   busy;
    logic [2:0]    fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    wb_write_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
        .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_wa(lng_wa), .lng_wd(lng_wd),
        .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is an ordered list of pending writes.
    typedef struct {
        logic          live;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } ent_t;

    ent_t          q[$];
    logic          m_we = 1'b0;
    logic [AW-1:0] m_wa = '0;
    logic [DW-1:0] m_wd = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_we = 1'b0;
            m_wa = '0;
            m_wd = '0;
        end else begin
            automatic bit   accept = lng_valid && (q.size() < DEPTH);
            automatic ent_t h;
            if (alu_we && alu_wa != 5'd31) begin
                foreach (q[i]) if (q[i].wa == alu_wa) q[i].live = 1'b0;
                m_we = 1'b1; m_wa = alu_wa; m_wd = alu_wd;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                m_we = h.live; m_wa = h.wa; m_wd = h.wd;
            end else begin
                m_we = 1'b0;
            end
            if (accept && lng_wa != 5'd31) q.push_back('{1'b1, lng_wa, lng_wd});
        end
    end

    always @(negedge clk) begin
        automatic logic [31:0] m_busy = '0;
        foreach (q[i]) if (q[i].live) m_busy[q[i].wa] = 1'b1;
        check("we3", we3, m_we);
        check("wa3", wa3, m_wa);
        check("wd3", wd3, m_wd);
        check("busy", busy, m_busy);
        check("fifo_count", fifo_count, q.size());
        check("lng_ready", lng_ready, !reset && q.size() < DEPTH);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        alu_we = 0; alu_wa = '0; alu_wd = '0;
        lng_valid = 0; lng_wa = '0; lng_wd = '0;
    endtask

    task automatic alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        alu_we = 1; alu_wa = a; alu_wd = d;
    endtask

    task automatic lng(input logic [AW-1:0] a, input logic [DW-1:0] d);
        lng_valid = 1; lng_wa = a; lng_wd = d;
    endtask

    function automatic logic [AW-1:0] pick_reg();
        int r = $urandom_range(0, 9);
        return (r == 9) ? 5'd31 : AW'(r);
    endfunction

    initial begin
        reset = 1'b1;
        idle();
        #2;
        check("rst_we3", we3, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", lng_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rel_ready", lng_ready, 1);

        // Plain ALU write, idle, then a discarded XZR write.
        alu(5, 64'hAA); tick();
        check("alu_we3", we3, 1); check("alu_wa3", wa3, 5); check("alu_wd3", wd3, 64'hAA);
        idle(); tick();
        check("alu_idle_we3", we3, 0);
        alu(31, 64'h77); tick();
        check("alu_xzr_we3", we3, 0);

        // Fill under continuous ALU traffic, then drain.
        for (int i = 0; i < 4; i++) begin
            alu(20, 64'h1234);
            lng(AW'(i + 1), 64'(16 * (i + 1)));
            tick();
        end
        check("fill_count", fifo_count, 4);
        check("fill_ready", lng_ready, 0);
        check("fill_busy", busy, 32'h1E);
        idle(); tick();
        check("drain_ready", lng_ready, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            check("drain_we3", we3, 1);
            check("drain_wa3", wa3, i + 1);
            check("drain_wd3", wd3, 16 * (i + 1));
        end
        tick();
        check("drain_end_we3", we3, 0);

        // Long-latency result with idle pipeline.
        lng(9, 64'h99); tick();
        check("x9_busy_pend", busy[9], 1);
        check("x9_we3_pend", we3, 0);
        idle(); tick();
        check("x9_we3", we3, 1); check("x9_wa3", wa3, 9); check("x9_wd3", wd3, 64'h99);
        check("x9_busy_done", busy[9], 0);

        // WAW squash of an older queued write.
        idle(); tick();
        lng(7, 64'h11); tick();
        idle(); alu(7, 64'h22); tick();
        check("waw_we3", we3, 1); check("waw_wd3", wd3, 64'h22);
        check("waw_busy7", busy[7], 0); check("waw_count", fifo_count, 1);
        idle(); tick();
        check("waw_killed_we3", we3, 0); check("waw_count_end", fifo_count, 0);

        // Same-edge ALU and long-latency write to one register: ALU first.
        alu(9, 64'h3); lng(9, 64'h5); tick();
        check("same_wd3", wd3, 64'h3); check("same_busy9", busy[9], 1);
        idle(); tick();
        check("same_pop_we3", we3, 1); check("same_pop_wd3", wd3, 64'h5);
        check("same_busy_end", busy, 0);

        // Reset mid-operation with three entries queued.
        for (int i = 0; i < 3; i++) begin
            alu(20, 64'h1); lng(AW'(i + 1), 64'(i)); tick();
        end
        check("pre_rst_count", fifo_count, 3);
        check("pre_rst_we3", we3, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_we3", we3, 0); check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", busy, 0); check("mid_rst_ready", lng_ready, 0);
        idle();
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_ready", lng_ready, 1);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            alu_we    = ($urandom_range(0, 99) < 40);
            alu_wa    = pick_reg();
            alu_wd    = {$urandom, $urandom};
            lng_valid = ($urandom_range(0, 99) < 50);
            lng_wa    = pick_reg();
            lng_wd    = {$urandom, $urandom};
            tick();
        end
        idle();
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
